// File: rtl/m68k_periph_waitgen.sv
// Wait-state and DTACK-trigger generator for the m68kdecoder peripheral chip selects.
// Optional watchdog: define WAITGEN_TIMEOUT_EN to force ERR when SETUP/STROBE exceeds TIMEOUT cycles.
module m68k_periph_waitgen #(
    parameter int unsigned WAIT_CS0 = 2,
    parameter int unsigned WAIT_CS1 = 3,
    parameter int unsigned WAIT_CS2 = 4,
    parameter int unsigned WAIT_CS3 = 6,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       clk16,
    input  logic       reset_n,
    input  logic       as_n,
    input  logic       rw,
    input  logic       uds_n,
    input  logic       lds_n,
    input  logic [3:0] cs,
    input  logic       periph_rdy_n,
    output logic       dtack_trig,
    output logic [3:0] per_cs_n,
    output logic       per_rd_n,
    output logic       per_wr_n,
    output logic [1:0] per_be_n,
    output logic       berr_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_ACK    = 3'd3,
        S_HOLD   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [3:0] W_CS0 = 4'(WAIT_CS0);
    localparam logic [3:0] W_CS1 = 4'(WAIT_CS1);
    localparam logic [3:0] W_CS2 = 4'(WAIT_CS2);
    localparam logic [3:0] W_CS3 = 4'(WAIT_CS3);

    function automatic logic cs_is_multi(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    function automatic logic cs_is_onehot(input logic [3:0] v);
        return (v != 4'd0) && !cs_is_multi(v);
    endfunction

    function automatic logic [1:0] cs_encode(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b0001: r = 2'd0;
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] idx_decode(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] wait_for(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = W_CS0;
            2'd1:    r = W_CS1;
            2'd2:    r = W_CS2;
            2'd3:    r = W_CS3;
            default: r = W_CS0;
        endcase
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       rw_q, rw_d;
    logic [1:0] be_q, be_d;
    logic [3:0] cnt_q, cnt_d;
    logic       timeout_s;

    logic       dtack_q, dtack_d;
    logic [3:0] cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic [1:0] be_n_q, be_n_d;
    logic       berr_q, berr_d;
    logic       busy_q, busy_d;

`ifdef WAITGEN_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [7:0] wdog_q, wdog_d;
    logic [7:0] wdog_inc_s;

    assign wdog_inc_s = wdog_q + 8'd1;
    assign timeout_s  = ((state_q == S_SETUP) || (state_q == S_STROBE)) && (wdog_inc_s == TMO);

    // Watchdog next value: cleared in IDLE, counting in SETUP/STROBE, frozen elsewhere.
    always_comb begin
        wdog_d = wdog_q;
        case (state_q)
            S_IDLE:            wdog_d = 8'd0;
            S_SETUP, S_STROBE: wdog_d = wdog_inc_s;
            default:           wdog_d = wdog_q;
        endcase
    end

    // Watchdog register.
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Bus-cycle state machine next-state and latch control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!as_n && cs_is_onehot(cs)) begin
                    idx_d   = cs_encode(cs);
                    rw_d    = rw;
                    be_d    = {uds_n, lds_n};
                    state_d = S_SETUP;
                end else if (!as_n && cs_is_multi(cs)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (as_n) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = wait_for(idx_q);
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                // cnt_q == 0 only occurs while cs[3] is parked waiting for ready
                if (as_n) begin
                    state_d = S_IDLE;
                end else if ((cnt_q <= 4'd1) && ((idx_q != 2'd3) || !periph_rdy_n)) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    state_d = S_STROBE;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  state_d = as_n ? S_IDLE : S_HOLD;
            S_ERR:   state_d = as_n ? S_IDLE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (timeout_s && !as_n) begin
            state_d = S_ERR;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        dtack_d = 1'b0;
        cs_n_d  = 4'hF;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        be_n_d  = 2'b11;
        berr_d  = 1'b0;
        busy_d  = 1'b1;
        case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_SETUP: begin
                cs_n_d = ~idx_decode(idx_d);
                be_n_d = be_d;
            end
            S_STROBE, S_ACK, S_HOLD: begin
                cs_n_d  = ~idx_decode(idx_d);
                be_n_d  = be_d;
                rd_n_d  = ~rw_d;
                wr_n_d  = rw_d;
                dtack_d = (state_d == S_ACK);
            end
            S_ERR:   berr_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // State, latched cycle attributes and registered outputs.
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            rw_q    <= 1'b0;
            be_q    <= 2'b11;
            cnt_q   <= 4'd0;
            dtack_q <= 1'b0;
            cs_n_q  <= 4'hF;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            be_n_q  <= 2'b11;
            berr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            dtack_q <= dtack_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            be_n_q  <= be_n_d;
            berr_q  <= berr_d;
            busy_q  <= busy_d;
        end
    end

    assign dtack_trig = dtack_q;
    assign per_cs_n   = cs_n_q;
    assign per_rd_n   = rd_n_q;
    assign per_wr_n   = wr_n_q;
    assign per_be_n   = be_n_q;
    assign berr_req   = berr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_m68k_periph_waitgen.sv
// Randomized bench for m68k_periph_waitgen: each bus transaction is expanded by a
// transaction-level model into a per-cycle list of inputs and expected outputs, then replayed.
module tb_m68k_periph_waitgen;

    logic       clk16 = 1'b0;
    logic       reset_n = 1'b0;
    logic       as_n = 1'b1;
    logic       rw = 1'b1;
    logic       uds_n = 1'b1;
    logic       lds_n = 1'b1;
    logic [3:0] cs = 4'd0;
    logic       periph_rdy_n = 1'b1;
    logic       dtack_trig;
    logic [3:0] per_cs_n;
    logic       per_rd_n;
    logic       per_wr_n;
    logic [1:0] per_be_n;
    logic       berr_req;
    logic       busy;

    int n_checks = 0;
    int n_bad    = 0;
    int waits[4] = '{2, 3, 4, 6};

    m68k_periph_waitgen dut (
        .clk16       (clk16),
        .reset_n     (reset_n),
        .as_n        (as_n),
        .rw          (rw),
        .uds_n       (uds_n),
        .lds_n       (lds_n),
        .cs          (cs),
        .periph_rdy_n(periph_rdy_n),
        .dtack_trig  (dtack_trig),
        .per_cs_n    (per_cs_n),
        .per_rd_n    (per_rd_n),
        .per_wr_n    (per_wr_n),
        .per_be_n    (per_be_n),
        .berr_req    (berr_req),
        .busy        (busy)
    );

    always #5 clk16 = ~clk16;

    typedef struct {
        logic       rst_n;
        logic       as_n;
        logic       rw;
        logic [1:0] be;
        logic [3:0] cs;
        logic       rdy_n;
        logic [10:0] exp;
    } step_t;

    step_t steps[$];

    // Output vector layout: {per_cs_n, per_rd_n, per_wr_n, per_be_n, dtack_trig, berr_req, busy}
    function automatic logic [10:0] exp_vec(input logic [3:0] csn, input logic rd, input logic wr,
                                            input logic [1:0] be, input logic dt, input logic be_rr,
                                            input logic bz);
        return {csn, rd, wr, be, dt, be_rr, bz};
    endfunction

    localparam logic [10:0] IDLE_V = {4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] ERR_V  = {4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};

    function automatic logic rbit();
        logic [31:0] v;
        v = $urandom;
        return v[0];
    endfunction

    function automatic logic [1:0] rbe();
        logic [31:0] v;
        v = $urandom;
        return v[1:0];
    endfunction

    function automatic logic [3:0] rnib();
        logic [31:0] v;
        v = $urandom;
        return v[3:0];
    endfunction

    task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%b exp=%b (cs_n,rd,wr,be,dtack,berr,busy)", tag, obs, exp);
        end
    endtask

    task automatic push(input logic r, input logic a, input logic [3:0] c, input logic rdy,
                        input logic rwv, input logic [1:0] bev, input logic [10:0] e);
        step_t st;
        st.rst_n = r;
        st.as_n  = a;
        st.cs    = c;
        st.rdy_n = rdy;
        st.rw    = rwv;
        st.be    = bev;
        st.exp   = e;
        steps.push_back(st);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            push(1'b1, 1'b1, rnib(), rbit(), rbit(), rbe(), IDLE_V);
        end
    endtask

    // One legal transfer: select, SETUP, S strobe cycles, ACK, HOLD until as_n rises.
    // abort_at = c releases as_n during cycle c after the select (0 = SETUP); -1 = no abort.
    task automatic build_legal(input int idx, input logic rwv, input logic [1:0] bev, input int r,
                               input int h, input int abort_at, input int gap);
        int          s;
        logic [3:0]  oh;
        logic [10:0] sel_v, str_v, ack_v;
        logic        rdyv;
        logic        done;
        s     = (idx == 3 && r > waits[idx]) ? r : waits[idx];
        oh    = 4'b0001 << idx;
        sel_v = exp_vec(~oh, 1'b1, 1'b1, bev, 1'b0, 1'b0, 1'b1);
        str_v = exp_vec(~oh, ~rwv, rwv, bev, 1'b0, 1'b0, 1'b1);
        ack_v = exp_vec(~oh, ~rwv, rwv, bev, 1'b1, 1'b0, 1'b1);
        done  = 1'b0;
        push(1'b1, 1'b0, oh, rbit(), rwv, bev, sel_v);
        for (int k = 1; k <= s + 1; k++) begin
            if (!done && abort_at == k - 1) begin
                push(1'b1, 1'b1, rnib(), rbit(), rbit(), rbe(), IDLE_V);
                done = 1'b1;
            end else if (!done) begin
                rdyv = (idx == 3) ? ((k - 1 >= r) ? 1'b0 : 1'b1) : rbit();
                push(1'b1, 1'b0, rnib(), rdyv, rbit(), rbe(), (k <= s) ? str_v : ack_v);
            end
        end
        if (!done) begin
            push(1'b1, 1'b0, rnib(), rbit(), rbit(), rbe(), str_v);
            for (int i = 0; i < h; i++) begin
                push(1'b1, 1'b0, rnib(), rbit(), rbit(), rbe(), str_v);
            end
            push(1'b1, 1'b1, rnib(), rbit(), rbit(), rbe(), IDLE_V);
        end
        idle_gap(gap);
    endtask

    task automatic build_illegal(input logic [3:0] c, input int n, input int gap);
        push(1'b1, 1'b0, c, rbit(), rbit(), rbe(), ERR_V);
        for (int i = 0; i < n; i++) begin
            push(1'b1, 1'b0, rnib(), rbit(), rbit(), rbe(), ERR_V);
        end
        push(1'b1, 1'b1, rnib(), rbit(), rbit(), rbe(), IDLE_V);
        idle_gap(gap);
    endtask

    task automatic play(input string tag);
        for (int i = 0; i < steps.size(); i++) begin
            @(negedge clk16);
            reset_n      = steps[i].rst_n;
            as_n         = steps[i].as_n;
            cs           = steps[i].cs;
            rw           = steps[i].rw;
            uds_n        = steps[i].be[1];
            lds_n        = steps[i].be[0];
            periph_rdy_n = steps[i].rdy_n;
            @(posedge clk16);
            #1;
            check_eq(tag, {per_cs_n, per_rd_n, per_wr_n, per_be_n, dtack_trig, berr_req, busy},
                     steps[i].exp);
        end
        steps.delete();
    endtask

    initial begin
        int          sel;
        int          idx;
        int          ab;
        logic [3:0]  c;

        // reset held with a live select, then release starts a cycle immediately
        push(1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'b01, IDLE_V);
        push(1'b0, 1'b0, 4'b0001, 1'b1, 1'b1, 2'b01, IDLE_V);
        play("reset");
        build_legal(0, 1'b1, 2'b01, 1, 2, -1, 1);
        play("read_cs0");

        build_legal(2, 1'b0, 2'b00, 1, 1, -1, 1);
        play("write_cs2");

        build_legal(3, 1'b1, 2'b11, 11, 0, -1, 1);
        play("ready_cs3");

        build_legal(3, 1'b0, 2'b10, 2, 1, -1, 1);
        play("early_ready_cs3");

        build_illegal(4'b0011, 3, 1);
        play("multi_sel");

        build_legal(1, 1'b1, 2'b10, 1, 0, 2, 1);
        play("abort_cs1");

        build_legal(0, 1'b0, 2'b00, 1, 0, 0, 1);
        play("abort_setup");

        // reset mid-cycle during STROBE of cs[2]
        push(1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'b00,
             exp_vec(4'b1011, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1));
        push(1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'b00,
             exp_vec(4'b1011, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        push(1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 2'b00, IDLE_V);
        push(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 2'b00, IDLE_V);
        play("mid_reset");

`ifdef WAITGEN_TIMEOUT_EN
        push(1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 2'b11,
             exp_vec(4'b0111, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < 64; k++) begin
            push(1'b1, 1'b0, rnib(), 1'b1, rbit(), rbe(),
                 exp_vec(4'b0111, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1));
        end
        push(1'b1, 1'b0, rnib(), 1'b1, rbit(), rbe(), ERR_V);
        push(1'b1, 1'b1, rnib(), 1'b1, rbit(), rbe(), IDLE_V);
        play("timeout_cs3");
`endif

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                c = rnib();
                while ($countones(c) < 2) c = rnib();
                build_illegal(c, $urandom_range(0, 3), $urandom_range(0, 2));
                play("rand_err");
            end else if (sel == 2) begin
                for (int i = 0; i < 3; i++) begin
                    push(1'b1, 1'b0, 4'b0000, rbit(), rbit(), rbe(), IDLE_V);
                end
                idle_gap(1);
                play("rand_idle");
            end else begin
                idx = $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) begin
                    ab = $urandom_range(0, waits[idx]);
                end else begin
                    ab = -1;
                end
                build_legal(idx, rbit(), rbe(), $urandom_range(1, 12), $urandom_range(0, 3), ab,
                            $urandom_range(0, 2));
                play("rand_xfer");
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/m68k_periph_waitgen.md
Name: m68k_periph_waitgen

Overview:
Wait-state and DTACK-trigger generator for the peripheral chip selects.
- Sits directly downstream of m68kdecoder: consumes its one-hot cs[3:0] and drives its dtack_trig input.
- Produces per-peripheral strobes with per-select wait counts, plus an external-ready extension on cs[3].
- Raises a bus-error request on illegal selects or a stalled peripheral.

Parameters:
WAIT_CS0, 2, strobe cycles before acknowledge for cs[0] (1..15)
WAIT_CS1, 3, strobe cycles before acknowledge for cs[1] (1..15)
WAIT_CS2, 4, strobe cycles before acknowledge for cs[2] (1..15)
WAIT_CS3, 6, minimum strobe cycles for cs[3]; then wait for ready (1..15)
TIMEOUT, 64, watchdog limit in clk16 cycles, counted from SETUP (16..255)

Ports:
clk16  in  1  CPU clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
as_n  in  1  CPU address strobe, active low
rw  in  1  1 = read, 0 = write
uds_n  in  1  upper data strobe, active low
lds_n  in  1  lower data strobe, active low
cs  in  4  decoded peripheral selects from m68kdecoder, active high, one-hot
periph_rdy_n  in  1  ready from the cs[3] device, active low
dtack_trig  out  1  one-cycle pulse to m68kdecoder requesting DTACK
per_cs_n  out  4  registered peripheral chip selects, active low
per_rd_n  out  1  peripheral read strobe
per_wr_n  out  1  peripheral write strobe
per_be_n  out  2  latched {uds_n, lds_n}
berr_req  out  1  bus-error request, held until as_n goes high
busy  out  1  high in any state except IDLE

Behaviour:
Reset:
- Sampled on the clk16 edge while reset_n = 0.
- State goes to IDLE, counters clear.
- Output values: per_cs_n = 4'hF, per_rd_n = per_wr_n = 1, per_be_n = 2'b11, dtack_trig = 0, berr_req = 0, busy = 0.
- Reset asserted mid-cycle forces all outputs to these values on the next edge.

State machine: IDLE -> SETUP -> STROBE -> ACK -> HOLD -> IDLE, plus ERR.
- IDLE: at the edge where as_n = 0 and cs is exactly one-hot:
  - latch the select index, rw and {uds_n, lds_n};
  - go to SETUP;
  - if cs = 0, stay in IDLE.
- Illegal select: as_n = 0 with more than one cs bit set goes to ERR; berr_req = 1 on the next cycle.
- SETUP: exactly 1 cycle.
  - per_cs_n[i] = 0, strobes inactive.
  - Load the wait counter with WAIT_CSi.
  - Go to STROBE.
- STROBE:
  - per_rd_n = 0 if rw = 1, otherwise per_wr_n = 0.
  - Counter decrements each cycle.
  - When the counter reaches 0, go to ACK.
  - For cs[3], also require periph_rdy_n = 0 at that edge; otherwise remain in STROBE with the counter held at 0.
- Latency example: with WAIT_CS0 = 2, the strobe is low for exactly 2 cycles, and dtack_trig is high in the 4th cycle after the select edge.
- ACK: dtack_trig = 1 for exactly 1 cycle; strobes and per_cs_n are held; go to HOLD.
- HOLD: strobes and per_cs_n are held until as_n = 1 is sampled, then go to IDLE on that edge (all outputs inactive).
- ERR:
  - berr_req = 1, all strobes and per_cs_n inactive, no dtack_trig.
  - Leave to IDLE when as_n = 1 is sampled.
- Abort: as_n = 1 sampled in SETUP or STROBE goes directly to IDLE, with no dtack_trig and no berr_req.
- Cycle boundaries:
  - A new cycle cannot start in the same edge on which HOLD or ERR exits.
  - as_n must be seen high at least once between cycles.
- cs changes after SETUP are ignored, because the index is latched.
- busy = 1 in SETUP, STROBE, ACK, HOLD and ERR.

Optional Feature:
Macro: WAITGEN_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog clears in IDLE and increments from SETUP.
  - Reaching TIMEOUT while in SETUP or STROBE forces ERR.
  - The watchdog does not run in ACK or HOLD.
- Undefined:
  - No watchdog logic; cs[3] may wait indefinitely for periph_rdy_n.
  - berr_req is asserted only for illegal multi-select.

Test Plan:
1. Reset with as_n = 0, cs = 4'b0001 -> all outputs at reset values; releasing reset starts a normal cycle from IDLE.
2. Read cs = 4'b0001, rw = 1, uds_n = 0, lds_n = 1:
   - per_cs_n = 4'b1110 from the cycle after the select edge;
   - per_rd_n low for 2 cycles, per_be_n = 2'b01;
   - one dtack_trig pulse;
   - outputs held until as_n rises, then inactive.
3. Write cs = 4'b0100, rw = 0 -> per_wr_n low for 4 cycles, per_rd_n stays 1, exactly one dtack_trig pulse.
4. cs = 4'b1000 with periph_rdy_n held high for 10 cycles, then low:
   - dtack_trig fires 1 cycle after ready is sampled low;
   - the strobe lasts at least 6 cycles.
5. cs = 4'b0011 -> berr_req = 1 from the next cycle, no strobes, no dtack_trig; berr_req cleared after as_n = 1.
6. With WAITGEN_TIMEOUT_EN, cs = 4'b1000 and periph_rdy_n stuck high:
   - berr_req asserts 64 cycles after SETUP and the strobe drops;
   - no dtack_trig.
   Also: as_n released during STROBE of cs[1] -> IDLE with no dtack_trig.
